// File: rtl/fetch_pkg.sv
// Shared definitions for the bitty core fetch stage: default widths and FSM state type.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EXEC,
    LOAD
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing stage: fetches the word at the PC, holds it until the
// core completes it, then loads the next PC from the branch stage.
module fetch_unit #(
  parameter int unsigned ADDR_W  = fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W = fetch_pkg::INSTR_W,
  parameter int unsigned CNT_W   = fetch_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  fetch_unit_if.master       mem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_address,
  input  logic               core_done,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  import fetch_pkg::*;

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // run is only looked at in IDLE and LOAD so an in-flight instruction always completes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (mem.mem_rvalid) state_d = EXEC;
      EXEC:    if (core_done) state_d = LOAD;
      LOAD:    state_d = run ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_address  <= '0;
      instruction <= '0;
      retired     <= '0;
    end else begin
      if (state_q == WAIT && mem.mem_rvalid) instruction <= mem.mem_rdata;
      if (state_q == EXEC && core_done)      retired     <= retired + CNT_W'(1);
      // new_pc is only valid the cycle after core_done, i.e. during LOAD
      if (state_q == LOAD)                   pc_address  <= new_pc;
    end
  end

  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = pc_address;
  assign instr_valid  = (state_q == EXEC);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-instruction transaction model with randomized
// memory latency, branch targets, spurious strobes and run drops.
module tb_fetch_unit;

  localparam int unsigned TB_CNT_W = 8;
  localparam int          CNT_MOD  = 1 << TB_CNT_W;

  logic                clk;
  logic                reset;
  logic                run;
  logic                core_done;
  logic [7:0]          new_pc;
  logic                instr_valid;
  logic [15:0]         instruction;
  logic [7:0]          pc_address;
  logic                busy;
  logic [TB_CNT_W-1:0] retired;

  fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) mem_bus ();

  fetch_unit #(
    .ADDR_W (8),
    .INSTR_W(16),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem        (mem_bus),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .pc_address (pc_address),
    .core_done  (core_done),
    .new_pc     (new_pc),
    .busy       (busy),
    .retired    (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem_img [256];
  logic [7:0]  model_pc;
  int          model_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   32'(mem_bus.mem_req), 0);
    check({tag, "_addr"},  32'(mem_bus.mem_addr), 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_instr"}, 32'(instruction), 0);
    check({tag, "_pc"},    32'(pc_address), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ret"},   32'(retired), 0);
  endtask

  // Entry: at the negedge of the REQ cycle. Exit: at the negedge of the next REQ cycle
  // (keep_run), a few cycles into IDLE (!keep_run), or just after reset release (abort).
  task automatic fetch_one(input int lat, input logic [7:0] target, input bit keep_run,
                           input bit spur, input int hold, input bit abort);
    logic [15:0] word;
    word = mem_img[model_pc];
    check("req",      32'(mem_bus.mem_req), 1);
    check("req_addr", 32'(mem_bus.mem_addr), 32'(model_pc));
    check("req_busy", 32'(busy), 1);
    check("req_valid", 32'(instr_valid), 0);
    run                = 1'b1;
    new_pc             = 8'($urandom);
    mem_bus.mem_rvalid = spur;
    mem_bus.mem_rdata  = 16'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      nclk();
      check("wait_req",   32'(mem_bus.mem_req), 0);
      check("wait_valid", 32'(instr_valid), 0);
      mem_bus.mem_rvalid = 1'b0;
      core_done          = (spur && k == 1);
      new_pc             = 8'($urandom);
      if (k == 1 && !keep_run) run = 1'b0;
      if (k == lat + 1) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = word;
      end
    end
    nclk();
    core_done = 1'b0;
    check("exec_valid", 32'(instr_valid), 1);
    check("exec_instr", 32'(instruction), 32'(word));
    mem_bus.mem_rvalid = spur;
    mem_bus.mem_rdata  = ~word;
    if (abort) begin
      #2 reset = 1'b0;
      #1 check_zero("abort");
      run                = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      nclk();
      reset     = 1'b1;
      model_pc  = '0;
      model_ret = 0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      nclk();
      check("hold_valid", 32'(instr_valid), 1);
      check("hold_instr", 32'(instruction), 32'(word));
      check("hold_ret",   32'(retired), 32'(model_ret % CNT_MOD));
      mem_bus.mem_rvalid = spur && ($urandom_range(1) == 1);
      mem_bus.mem_rdata  = 16'($urandom);
    end
    core_done = 1'b1;
    nclk();
    model_ret++;
    core_done          = 1'b0;
    new_pc             = target;
    mem_bus.mem_rvalid = spur;
    mem_bus.mem_rdata  = 16'($urandom);
    check("load_valid", 32'(instr_valid), 0);
    check("load_busy",  32'(busy), 1);
    check("load_ret",   32'(retired), 32'(model_ret % CNT_MOD));
    check("load_pc",    32'(pc_address), 32'(model_pc));
    check("load_instr", 32'(instruction), 32'(word));
    model_pc = target;
    nclk();
    mem_bus.mem_rvalid = 1'b0;
    new_pc             = 8'($urandom);
    if (!keep_run) begin
      for (int i = 0; i < 3; i++) begin
        check("idle_busy", 32'(busy), 0);
        check("idle_req",  32'(mem_bus.mem_req), 0);
        check("idle_pc",   32'(pc_address), 32'(model_pc));
        nclk();
      end
    end
  endtask

  task automatic start_run();
    run = 1'b1;
    nclk();
  endtask

  initial begin
    reset              = 1'b0;
    run                = 1'b0;
    core_done          = 1'b0;
    new_pc             = '0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
    model_pc           = '0;
    model_ret          = 0;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    mem_img[0] = 16'h1234;

    #1 check_zero("reset");
    nclk();
    reset = 1'b1;
    nclk();
    check("idle_after_reset", 32'(busy), 0);

    start_run();
    fetch_one(1, 8'h05, 1'b1, 1'b0, 0, 1'b0);
    fetch_one(4, 8'($urandom), 1'b1, 1'b1, 2, 1'b0);
    fetch_one(2, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
    start_run();
    fetch_one(1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    fetch_one(3, 8'h00, 1'b1, 1'b1, 1, 1'b0);

    // enough retirements to wrap the counter at least once
    for (int n = 0; n < CNT_MOD + 8; n++) begin
      bit stop;
      stop = ($urandom_range(15) == 0);
      fetch_one(int'($urandom_range(4, 1)), 8'($urandom), !stop, 1'($urandom),
                int'($urandom_range(3)), 1'b0);
      if (stop) start_run();
    end

    fetch_one(1, 8'h7F, 1'b1, 1'b0, 0, 1'b0);
    fetch_one(2, 8'h10, 1'b1, 1'b0, 0, 1'b1);
    check_zero("post_abort");
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 16'hBEEF;
    nclk();
    mem_bus.mem_rvalid = 1'b0;
    check("late_rvalid_instr", 32'(instruction), 0);
    check("late_rvalid_busy",  32'(busy), 0);
    start_run();
    fetch_one(1, 8'h22, 1'b0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage for the bitty core. Holds the current program counter and requests the instruction at that address from the instruction memory. It presents the returned word to the core until the core signals completion, then loads the next PC from the branch stage. It is the direct producer of `pc_address` and `instruction` for the branch stage and the consumer of its `new_pc`.

## Interface
- `ADDR_W`, 8: PC / memory address width
- `INSTR_W`, 16: instruction width
- `CNT_W`, 16: retired-instruction counter width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `run`  in  1  level; 1 = keep fetching, 0 = stop at next instruction boundary
- `mem_req`  out  1  single-cycle read request to instruction memory
- `mem_addr`  out  ADDR_W  read address, valid while `mem_req`=1
- `mem_rvalid`  in  1  read data valid (latency ≥1 cycle after `mem_req`)
- `mem_rdata`  in  INSTR_W  read data
- `instr_valid`  out  1  `instruction` is valid for the core to execute
- `instruction`  out  INSTR_W  registered instruction word
- `pc_address`  out  ADDR_W  PC of the instruction being executed
- `core_done`  in  1  one-cycle pulse: core finished the current instruction
- `new_pc`  in  ADDR_W  next PC from the branch stage; registered there on the `core_done` edge
- `busy`  out  1  state ≠ IDLE
- `retired`  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, REQ, WAIT, EXEC, LOAD.
- IDLE: `run`=1 → REQ.
- REQ: `mem_req`=1 and `mem_addr`=`pc_address` for exactly one cycle → WAIT.
- WAIT: on `mem_rvalid`=1, latch `mem_rdata` into `instruction` → EXEC.
- EXEC: `instr_valid`=1, held until `core_done`=1. On `core_done`, `retired` += 1 (wraps at 2^CNT_W) → LOAD.
- LOAD: `pc_address` ← `new_pc`. Then → REQ if `run`=1, else → IDLE.
- `run` deasserted during REQ, WAIT or EXEC: the current instruction completes normally, and the stage stops in IDLE after LOAD. `run` is sampled only in IDLE and LOAD.
- `mem_rvalid` outside WAIT: ignored, and no register changes.
- `core_done` outside EXEC: ignored.
- PC width is ADDR_W. `new_pc` arrives already truncated. 8'hFF → 8'h00 wrap is carried through unchanged.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `pc_address`=0, `instruction`=0, `instr_valid`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `retired`=0.
- Reset mid-operation aborts any outstanding memory read. A late `mem_rvalid` after reset release is ignored because the stage is in IDLE.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- LOAD lasts exactly one cycle. This is required because `new_pc` is valid only from the cycle after `core_done`.
- Fetch latency with memory latency L: REQ (1) + L + 1 → `instr_valid` rises L+2 cycles after entering REQ.
- Instruction turnaround from a `core_done` pulse to the next `mem_req`: 2 cycles (EXEC→LOAD, LOAD→REQ).
- `instr_valid` falls on the clock edge that samples `core_done`.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, REQ, WAIT, EXEC, LOAD) and default widths ADDR_W, INSTR_W, CNT_W.
- Single module. The PC, instruction and counter registers and the FSM are inline. No sub-module is warranted.

## Test plan
- Reset, then `run`=1, memory L=1, mem[0]=16'h1234 → `mem_req` with addr 0 one cycle after `run`; `instruction`=16'h1234 and `instr_valid`=1 three cycles after entering REQ.
- `core_done` pulse with `new_pc`=8'h05 → `instr_valid` drops the next edge, `pc_address`=8'h05 after LOAD, `mem_addr`=8'h05 two cycles after the pulse, `retired`=1.
- Memory L=4 with spurious `mem_rvalid` pulses in REQ and EXEC → spurious pulses ignored; `instruction` updates only from the WAIT-state response.
- `run` dropped during WAIT → current instruction executes, `core_done` accepted, then IDLE with `busy`=0 and `pc_address`=`new_pc`. No further `mem_req`.
- `reset` asserted in EXEC with pc=8'h7F → all outputs read zero immediately. After release with `run`=1, first fetch address is 8'h00.
- `pc_address`=8'hFF, `new_pc`=8'h00 → wrap: next `mem_addr`=8'h00. Also check `retired` wraps 16'hFFFF → 16'h0000.
